sqn_activity_monitor: RTL and testbench
=======================================

Name: sqn_activity_monitor

Overview:
- Downstream consumer of the 3-bit sqn benchmark output vector (v7.0..v7.2).
- Measures switching activity on those outputs over a programmable window of valid samples and reports per-bit and total toggle counts through a valid/ready report port.
- Feeds the power-aware synthesis flow's activity-estimation path; placed after the sqn logic, optionally behind its input register stage.

Parameters:
- OUT_W, 3, number of monitored output bits (bit i = v7.i)
- CNT_W, 16, width of each per-bit toggle counter
- WIN_W, 16, width of window length and sample counter

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; arms a measurement window (ignored unless IDLE)
- win_len  input  WIN_W  number of valid samples in window, captured on accepted start
- in_valid  input  1  in_data carries a valid sqn output sample this cycle
- in_data  input  OUT_W  sqn output vector {v7.2, v7.1, v7.0}
- busy  output  1  high in any state other than IDLE
- rpt_valid  output  1  report available
- rpt_ready  input  1  report consumer accepts report
- rpt_toggles  output  OUT_W*CNT_W  per-bit toggle counts, bit i in [i*CNT_W +: CNT_W]
- rpt_total  output  CNT_W+2  sum of per-bit counts
- rpt_samples  output  WIN_W  valid samples consumed in window

Behaviour:
- Reset: synchronous, active-high, single clock, named clk/rst. On rst at a rising edge: state=IDLE, busy=0, rpt_valid=0, all counters/report fields=0, baseline register=0. Reset mid-window or mid-report aborts with no report.
- FSM states: IDLE, BASE, COUNT, REPORT.
- IDLE:
  - start=1 -> capture win_len, clear counters.
  - win_len==0 -> REPORT next cycle with all counts 0, rpt_samples=0.
  - otherwise -> BASE.
- BASE: first in_valid sample stored as baseline, samples=1. If win_len==1 -> REPORT, else -> COUNT. Cycles without in_valid are ignored.
- COUNT: on each in_valid:
  - toggles[i] += (in_data[i] != prev[i]); prev <= in_data; samples += 1.
  - When samples reaches win_len on this sample -> REPORT.
- Comparison uses only valid samples; gaps in in_valid do not create toggles.
- Per-bit counters saturate at 2^CNT_W-1. rpt_total is the sum of the saturated values.
- Latency: rpt_valid asserts on the cycle after the edge that accepts the last window sample.
- REPORT:
  - rpt_valid=1; all rpt_* fields stable until handshake.
  - rpt_valid & rpt_ready -> IDLE next cycle, rpt_valid=0. Report fields hold their last value until the next start.
  - in_valid ignored; start ignored.
- start while busy: ignored, no effect on the running window.
- Simultaneous start and in_valid in IDLE: the sample is not consumed; the window begins next cycle.
- Simultaneous rst and any event: rst wins.

Test Plan:
- win_len=4; samples 000,111,111,010 -> rpt_toggles {b2=1,b1=1,b0=1}? expand: b0:0->1->1->0 =2, b1:0->1->1->1=1, b2:0->1->1->0=2; rpt_total=5, rpt_samples=4, rpt_valid 1 cycle after 4th sample.
- win_len=3, in_valid gaps of 5 idle cycles between samples 001,001,000 -> b0=1, others 0, total=1; idle cycles add nothing.
- win_len=0 start -> rpt_valid next cycle, all counts 0, samples 0. win_len=1 with sample 101 -> total 0, samples 1.
- rpt_ready held low 10 cycles -> rpt_valid and fields stable. Pulse start and in_valid during wait -> no change. rpt_ready=1 -> IDLE, busy=0 next cycle.
- CNT_W=4, win_len=20, bit0 alternating every sample -> toggles[0]=15 (saturated), rpt_total=15.
- rst asserted after 2 of 4 samples -> next cycle busy=0, rpt_valid=0, counters 0. New start, win_len=2, samples 000,100 -> b2=1, total 1.

Source files
------------

// File: rtl/sqn_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sqn_activity_monitor
// Brief    : Counts per-bit toggles on the sqn output vector over a window of
//            valid samples and returns the totals over a valid/ready port.
// Revision : 1.0  initial release
// ============================================================================
module sqn_activity_monitor #(
    parameter int OUT_W = 3,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WIN_W-1:0]       win_len,
    input  logic                   in_valid,
    input  logic [OUT_W-1:0]       in_data,
    output logic                   busy,
    output logic                   rpt_valid,
    input  logic                   rpt_ready,
    output logic [OUT_W*CNT_W-1:0] rpt_toggles,
    output logic [CNT_W+1:0]       rpt_total,
    output logic [WIN_W-1:0]       rpt_samples
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_base   = 2'd1;
    localparam logic [1:0] c_count  = 2'd2;
    localparam logic [1:0] c_report = 2'd3;

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIN_W-1:0] c_samp_one = {{(WIN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIN_W-1:0] r_win_len;
    logic [WIN_W-1:0] r_samples;
    logic [OUT_W-1:0] r_prev;
    logic [CNT_W-1:0] r_cnt     [OUT_W];
    logic [CNT_W-1:0] w_cnt_nxt [OUT_W];
    logic [WIN_W-1:0] w_samples_inc;
    logic [CNT_W+1:0] w_total;

    assign w_samples_inc = r_samples + c_samp_one;

    genvar g;
    generate
        for (g = 0; g < OUT_W; g++) begin : g_bit
            // Counters stick at all-ones so the report never wraps to a small value.
            assign w_cnt_nxt[g] = ((in_data[g] != r_prev[g]) && (r_cnt[g] != c_cnt_max))
                                  ? (r_cnt[g] + c_cnt_one) : r_cnt[g];
            assign rpt_toggles[g*CNT_W +: CNT_W] = r_cnt[g];
        end
    endgenerate

    always_comb begin
        w_total = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_total = w_total + {2'b00, r_cnt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_win_len <= '0;
            r_samples <= '0;
            r_prev    <= '0;
            for (int i = 0; i < OUT_W; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                c_idle: begin
                    // A sample arriving alongside start is not part of the window.
                    if (start) begin
                        r_win_len <= win_len;
                        r_samples <= '0;
                        for (int i = 0; i < OUT_W; i++) begin
                            r_cnt[i] <= '0;
                        end
                        r_state <= (win_len == '0) ? c_report : c_base;
                    end
                end
                c_base: begin
                    if (in_valid) begin
                        r_prev    <= in_data;
                        r_samples <= c_samp_one;
                        r_state   <= (r_win_len == c_samp_one) ? c_report : c_count;
                    end
                end
                c_count: begin
                    if (in_valid) begin
                        r_prev    <= in_data;
                        r_samples <= w_samples_inc;
                        for (int i = 0; i < OUT_W; i++) begin
                            r_cnt[i] <= w_cnt_nxt[i];
                        end
                        if (w_samples_inc == r_win_len) begin
                            r_state <= c_report;
                        end
                    end
                end
                c_report: begin
                    if (rpt_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign busy        = (r_state != c_idle);
    assign rpt_valid   = (r_state == c_report);
    assign rpt_total   = w_total;
    assign rpt_samples = r_samples;

endmodule
`default_nettype wire

// File: tb/tb_sqn_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sqn_activity_monitor
// Brief    : Scoreboard bench; a 16-bit and a 4-bit counter instance share the
//            same stimulus so saturation is seen against the unsaturated case.
// Revision : 1.0  initial release
// ============================================================================
module tb_sqn_activity_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] win_len = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_data = '0;
    logic        rpt_ready = 1'b1;

    logic        busy16, rv16, busy4, rv4;
    logic [47:0] tog16;
    logic [17:0] tot16;
    logic [15:0] smp16;
    logic [11:0] tog4;
    logic [5:0]  tot4;
    logic [15:0] smp4;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int t0;
        int t1;
        int t2;
        int s;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    exp_t e16, e4;

    always #5 clk = ~clk;

    sqn_activity_monitor #(.OUT_W(3), .CNT_W(16), .WIN_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_data(in_data), .busy(busy16),
        .rpt_valid(rv16), .rpt_ready(rpt_ready), .rpt_toggles(tog16),
        .rpt_total(tot16), .rpt_samples(smp16)
    );

    sqn_activity_monitor #(.OUT_W(3), .CNT_W(4), .WIN_W(16)) dut4 (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_data(in_data), .busy(busy4),
        .rpt_valid(rv4), .rpt_ready(rpt_ready), .rpt_toggles(tog4),
        .rpt_total(tot4), .rpt_samples(smp4)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int t0, input int t1, input int t2, input int s);
        exp_t e;
        e.t0 = t0; e.t1 = t1; e.t2 = t2; e.s = s;
        q16.push_back(e);
        q4.push_back(e);
    endtask

    task automatic do_start(input int wl);
        start   = 1'b1;
        win_len = wl[15:0];
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input logic [2:0] d, input int gap);
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic chk_report_up(input string name);
        chk({name, "_rv16"}, rv16, 1);
        chk({name, "_rv4"}, rv4, 1);
    endtask

    task automatic finish_report(input string name);
        tick();
        chk({name, "_idle16"}, busy16, 0);
        chk({name, "_idle4"}, busy4, 0);
    endtask

    // Monitor: pops one expected report per accepted handshake on each instance.
    always @(negedge clk) begin
        if (!rst && rv16 && rpt_ready) begin
            if (q16.size() == 0) chk("unexpected_report16", 1, 0);
            else begin
                e16 = q16.pop_front();
                chk("tog0_16", tog16[15:0], e16.t0);
                chk("tog1_16", tog16[31:16], e16.t1);
                chk("tog2_16", tog16[47:32], e16.t2);
                chk("total_16", tot16, e16.t0 + e16.t1 + e16.t2);
                chk("samples_16", smp16, e16.s);
            end
        end
        if (!rst && rv4 && rpt_ready) begin
            if (q4.size() == 0) chk("unexpected_report4", 1, 0);
            else begin
                e4 = q4.pop_front();
                chk("tog0_4", tog4[3:0], sat4(e4.t0));
                chk("tog1_4", tog4[7:4], sat4(e4.t1));
                chk("tog2_4", tog4[11:8], sat4(e4.t2));
                chk("total_4", tot4, sat4(e4.t0) + sat4(e4.t1) + sat4(e4.t2));
                chk("samples_4", smp4, e4.s);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        chk("rst_busy16", busy16, 0);
        chk("rst_rv16", rv16, 0);
        chk("rst_tog16", tog16, 0);
        chk("rst_total16", tot16, 0);
        chk("rst_samples16", smp16, 0);
        chk("rst_busy4", busy4, 0);
        rst = 1'b0;
        tick();

        // Basic window of 4.
        push_exp(2, 1, 2, 4);
        do_start(4);
        send(3'b000, 0); send(3'b111, 0); send(3'b111, 0);
        chk("w4_no_early_rv", rv16, 0);
        send(3'b010, 0);
        chk_report_up("w4");
        finish_report("w4");

        // Gaps between valid samples contribute nothing.
        push_exp(1, 0, 0, 3);
        do_start(3);
        send(3'b001, 5); send(3'b001, 5);
        chk("gap_busy", busy16, 1);
        send(3'b000, 5);
        chk_report_up("gap");
        finish_report("gap");

        // Zero-length window reports right away.
        push_exp(0, 0, 0, 0);
        do_start(0);
        chk_report_up("w0");
        finish_report("w0");

        // Single-sample window.
        push_exp(0, 0, 0, 1);
        do_start(1);
        send(3'b101, 0);
        chk_report_up("w1");
        finish_report("w1");

        // Back-pressure: report held stable, start/in_valid ignored.
        push_exp(1, 0, 1, 2);
        do_start(2);
        send(3'b011, 0);
        rpt_ready = 1'b0;
        send(3'b110, 0);
        for (int k = 0; k < 10; k++) begin
            chk("hold_rv16", rv16, 1);
            chk("hold_total16", tot16, 2);
            chk("hold_samples16", smp16, 2);
            chk("hold_tog16", tog16, 48'h0001_0000_0001);
            if (k == 3) begin
                start = 1'b1; win_len = 16'd7; in_valid = 1'b1; in_data = 3'b111;
            end
            tick();
            start = 1'b0; in_valid = 1'b0;
        end
        rpt_ready = 1'b1;
        finish_report("hold");

        // Saturation on the 4-bit instance: 19 toggles vs 15.
        push_exp(19, 0, 0, 20);
        do_start(20);
        for (int k = 0; k < 20; k++) send((k % 2) ? 3'b001 : 3'b000, 0);
        chk_report_up("sat");
        finish_report("sat");

        // Reset mid-window aborts, then start coincident with a sample.
        do_start(4);
        send(3'b000, 0); send(3'b111, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy16", busy16, 0);
        chk("abort_rv16", rv16, 0);
        chk("abort_tog16", tog16, 0);
        chk("abort_tog4", tog4, 0);
        push_exp(0, 0, 1, 2);
        start = 1'b1; win_len = 16'd2; in_valid = 1'b1; in_data = 3'b111;
        tick();
        start = 1'b0; in_valid = 1'b0;
        send(3'b000, 0); send(3'b100, 0);
        chk_report_up("post_rst");
        finish_report("post_rst");

        repeat (3) tick();
        chk("q16_drained", q16.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
